// File: rtl/iob_mul_shiftadd_if.sv
// Start/done handshake bundle for the shift-add multiply-accumulate unit.
// The master issues operands and start; the slave returns done and product.
interface iob_mul_shiftadd_if #(
    parameter int DATA_W = 8
);
    logic                start_i;
    logic                done_o;
    logic [DATA_W-1:0]   multiplicand_i;
    logic [DATA_W-1:0]   multiplier_i;
    logic [DATA_W-1:0]   addend_i;
    logic [2*DATA_W-1:0] product_o;

    modport master (
        output start_i, multiplicand_i, multiplier_i, addend_i,
        input  done_o, product_o
    );

    modport slave (
        input  start_i, multiplicand_i, multiplier_i, addend_i,
        output done_o, product_o
    );
endinterface

// File: rtl/iob_mul_shiftadd.sv
// Sequential unsigned multiply-accumulate: product = multiplicand * multiplier + addend.
// The multiplier is consumed one bit per enabled cycle.
// state | meaning
// IDLE  | result valid, done high, start sampled
// RUN   | one multiplier bit processed per enabled edge
module iob_mul_shiftadd #(
    parameter int DATA_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cke_i,
    iob_mul_shiftadd_if.slave  bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] product_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] add_term;
    logic [2*DATA_W-1:0] acc_sum;
    logic                last_bit;

    // Partial product for the current multiplier bit, weighted by the bit position.
    assign add_term = mplier_q[0] ? ({{DATA_W{1'b0}}, mcand_q} << cnt_q) : '0;
    assign acc_sum  = acc_q + add_term;
    assign last_bit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else if (cke_i) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start_i) state_d = S_RUN;
            S_RUN:   if (last_bit)    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
        end else if (cke_i) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        mcand_q  <= bus.multiplicand_i;
                        mplier_q <= bus.multiplier_i;
                        acc_q    <= {{DATA_W{1'b0}}, bus.addend_i};
                        cnt_q    <= '0;
                    end
                end
                S_RUN: begin
                    acc_q    <= acc_sum;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_bit) begin
                        product_q <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.done_o    = (state_q == S_IDLE);
        bus.product_o = product_q;
    end
endmodule

// File: tb/tb_iob_mul_shiftadd.sv
// Directed bench for iob_mul_shiftadd with DATA_W=8, plus a divider round trip.
module tb_iob_mul_shiftadd;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cke = 1'b1;
    int   checks = 0;
    int   errors = 0;

    iob_mul_shiftadd_if #(.DATA_W(DATA_W)) bus ();

    iob_mul_shiftadd #(.DATA_W(DATA_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .cke_i (cke),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a start, scramble operands afterwards, count edges until done.
    task automatic run_op(input logic [7:0] mc, input logic [7:0] mp, input logic [7:0] ad,
                          output int lat, output logic [15:0] prod);
        bus.start_i        = 1'b1;
        bus.multiplicand_i = mc;
        bus.multiplier_i   = mp;
        bus.addend_i       = ad;
        step();
        bus.start_i        = 1'b0;
        bus.multiplicand_i = 8'($urandom);
        bus.multiplier_i   = 8'($urandom);
        bus.addend_i       = 8'($urandom);
        checks++;
        if (bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL start_done_low got %b want 0", bus.done_o);
        end
        lat = 0;
        while (bus.done_o !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        prod = bus.product_o;
    endtask

    task automatic test_reset();
        cke = 1'b0;
        rst = 1'b1;
        step();
        step();
        checks++;
        if (bus.done_o !== 1'b1 || bus.product_o !== 16'd0) begin
            errors++;
            $display("FAIL reset got done=%b prod=%0d want done=1 prod=0", bus.done_o, bus.product_o);
        end
        rst = 1'b0;
        cke = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int lat;
        logic [15:0] p;
        logic [7:0] vec [4][4];
        vec[0] = '{8'd13,  8'd11,  8'd7,   8'd0};
        vec[1] = '{8'd255, 8'd255, 8'd255, 8'd0};
        vec[2] = '{8'd0,   8'd200, 8'd9,   8'd0};
        vec[3] = '{8'd200, 8'd0,   8'd0,   8'd0};
        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp;
            case (i)
                0: exp = 16'd150;
                1: exp = 16'd65280;
                2: exp = 16'd9;
                default: exp = 16'd0;
            endcase
            run_op(vec[i][0], vec[i][1], vec[i][2], lat, p);
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL basic_latency[%0d] got %0d want 8", i, lat);
            end
            checks++;
            if (p !== exp) begin
                errors++;
                $display("FAIL basic_product[%0d] got %0d want %0d", i, p, exp);
            end
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        logic [15:0] p;
        bus.start_i        = 1'b1;
        bus.multiplicand_i = 8'd3;
        bus.multiplier_i   = 8'd5;
        bus.addend_i       = 8'd1;
        step();
        bus.start_i = 1'b0;
        lat = 0;
        while (bus.done_o !== 1'b1 && lat < 40) begin
            if (lat == 4) begin
                bus.start_i        = 1'b1;
                bus.multiplicand_i = 8'd100;
                bus.multiplier_i   = 8'd100;
                bus.addend_i       = 8'd100;
            end else begin
                bus.start_i = 1'b0;
            end
            step();
            lat++;
        end
        bus.start_i = 1'b0;
        checks++;
        if (lat !== 8 || bus.product_o !== 16'd16) begin
            errors++;
            $display("FAIL ignore_start got lat=%0d prod=%0d want lat=8 prod=16", lat, bus.product_o);
        end
        step();
        checks++;
        if (bus.done_o !== 1'b1 || bus.product_o !== 16'd16) begin
            errors++;
            $display("FAIL idle_hold got done=%b prod=%0d want done=1 prod=16", bus.done_o, bus.product_o);
        end
        run_op(8'd100, 8'd100, 8'd100, lat, p);
        checks++;
        if (lat !== 8 || p !== 16'd10100) begin
            errors++;
            $display("FAIL after_ignore got lat=%0d prod=%0d want lat=8 prod=10100", lat, p);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [15:0] p;
        bus.start_i        = 1'b1;
        bus.multiplicand_i = 8'd20;
        bus.multiplier_i   = 8'd20;
        bus.addend_i       = 8'd0;
        step();
        bus.start_i = 1'b0;
        step();
        step();
        step();
        checks++;
        if (bus.done_o !== 1'b0 || bus.product_o !== 16'd10100) begin
            errors++;
            $display("FAIL run_holds_prod got done=%b prod=%0d want done=0 prod=10100", bus.done_o, bus.product_o);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.done_o !== 1'b1 || bus.product_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid got done=%b prod=%0d want done=1 prod=0", bus.done_o, bus.product_o);
        end
        run_op(8'd2, 8'd3, 8'd4, lat, p);
        checks++;
        if (lat !== 8 || p !== 16'd10) begin
            errors++;
            $display("FAIL after_reset got lat=%0d prod=%0d want lat=8 prod=10", lat, p);
        end
    endtask

    task automatic test_stall();
        int edges;
        bus.start_i        = 1'b1;
        bus.multiplicand_i = 8'd7;
        bus.multiplier_i   = 8'd9;
        bus.addend_i       = 8'd2;
        step();
        bus.start_i = 1'b0;
        edges = 0;
        repeat (3) begin
            step();
            edges++;
        end
        cke = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            edges++;
            checks++;
            if (bus.done_o !== 1'b0 || bus.product_o !== 16'd10) begin
                errors++;
                $display("FAIL stall_hold[%0d] got done=%b prod=%0d want done=0 prod=10", k, bus.done_o, bus.product_o);
            end
        end
        cke = 1'b1;
        while (bus.done_o !== 1'b1 && edges < 40) begin
            step();
            edges++;
        end
        checks++;
        if (edges !== 13 || bus.product_o !== 16'd65) begin
            errors++;
            $display("FAIL stall_result got edges=%0d prod=%0d want edges=13 prod=65", edges, bus.product_o);
        end
    endtask

    task automatic test_round_trip();
        int lat;
        logic [15:0] p;
        logic [7:0] dvd, dvs, q, r;
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            dvd = 8'($urandom_range(0, 255));
            dvs = 8'($urandom_range(1, 255));
            q   = dvd / dvs;
            r   = dvd % dvs;
            run_op(q, dvs, r, lat, p);
            checks++;
            if (lat !== 8 || p !== {8'd0, dvd}) begin
                errors++;
                if (bad < 10)
                    $display("FAIL round_trip[%0d] q=%0d d=%0d r=%0d got lat=%0d prod=%0d want lat=8 prod=%0d",
                             i, q, dvs, r, lat, p, dvd);
                bad++;
            end
        end
    endtask

    initial begin
        bus.start_i        = 1'b0;
        bus.multiplicand_i = '0;
        bus.multiplier_i   = '0;
        bus.addend_i       = '0;
        test_reset();
        test_basic();
        test_start_ignored();
        test_reset_mid();
        test_stall();
        test_round_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
